// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the pipelined data memory.
package data_mem_pkg;

  // Widest word the response struct can carry; DATA_W must not exceed it.
  localparam int RSP_DW = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              err;
    logic [RSP_DW-1:0] data;
  } rsp_t;

  // Number of byte-offset bits inside one word.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/data_mem_rsp_pipe.sv
// RD_LAT-deep response shift register; invalid entries are stored as all-zero.
module data_mem_rsp_pipe
  import data_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  rsp_t rsp_in,
  output rsp_t rsp_out
);

  rsp_t stg_q [RD_LAT];

  // Shift responses toward the output; zero fields of empty slots at entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= rsp_in.valid ? rsp_in : '0;
      for (int i = 1; i < RD_LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign rsp_out = stg_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_pipe.sv
// Synchronous data memory with request/response handshake, byte-enable
// stores, address checking, post-reset clear sweep and RD_LAT read latency.
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = off_bits(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  state_e           state;
  logic [IDX_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             accept;
  logic [31:0]      word_idx32;
  logic [IDX_W-1:0] widx;
  logic             misaligned;
  logic             out_of_range;
  logic             err;

  rsp_t             rsp_in;
  rsp_t             rsp_q;
  logic             unused_rsp_data;

  // Address decode: word index is the byte address without its offset bits;
  // widening to 32 bits keeps the range compare free of width surprises.
  assign accept       = req_valid && req_ready;
  assign word_idx32   = 32'(req_addr >> OFF_W);
  assign widx         = word_idx32[IDX_W-1:0];
  assign misaligned   = |req_addr[OFF_W-1:0];
  assign out_of_range = word_idx32 >= 32'(DEPTH);
  assign err          = misaligned || out_of_range;

  // INIT sweeps the clear counter over every word, then RUN accepts forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      clr_idx   <= '0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
          end
        end
        ST_RUN: req_ready <= 1'b1;
        default: begin
          state     <= ST_INIT;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: clear sweep during INIT, byte-enabled stores in RUN.
  // Errored stores are dropped so an out-of-range index never aliases.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_we && !err) begin
      for (int b = 0; b < NB; b++)
        if (req_be[b]) mem[widx][b*8 +: 8] <= req_wdata[b*8 +: 8];
    end
  end

  // Response entry for this cycle; the pipe's first stage samples the array
  // at the acceptance edge, which makes a store-then-load see new data.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.we    = req_we;
    rsp_in.err   = err;
    if (accept && !req_we && !err) rsp_in.data = RSP_DW'(mem[widx]);
  end

  data_mem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_q)
  );

  assign rsp_valid = rsp_q.valid;
  assign rsp_we    = rsp_q.we;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = rsp_q.data[DATA_W-1:0];

  // Bits above DATA_W in the shared struct are always zero here.
  assign unused_rsp_data = ^rsp_q.data;

endmodule
